// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C register-interface target: FSM states, ACK levels, R/W bit.
// Latency: n/a (constants only); backpressure: n/a.
package i2c_pkg;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_DEV_ADDR  = 4'd1;
    localparam logic [3:0] ST_DEV_ACK   = 4'd2;
    localparam logic [3:0] ST_RA_H      = 4'd3;
    localparam logic [3:0] ST_RA_L      = 4'd4;
    localparam logic [3:0] ST_RA_ACK    = 4'd5;
    localparam logic [3:0] ST_WR_DATA   = 4'd6;
    localparam logic [3:0] ST_WR_ACK    = 4'd7;
    localparam logic [3:0] ST_RD_LOAD   = 4'd8;
    localparam logic [3:0] ST_RD_DATA   = 4'd9;
    localparam logic [3:0] ST_RD_MACK   = 4'd10;
    localparam logic [3:0] ST_WAIT_STOP = 4'd11;

    localparam logic ACK      = 1'b0;
    localparam logic NACK     = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    // Pointer auto-increment; 8-bit mode wraps within the low byte.
    function automatic logic [15:0] addr_inc(input logic [15:0] a, input logic wide);
        return wide ? (a + 16'd1) : {8'h00, a[7:0] + 8'd1};
    endfunction

endpackage

// File: rtl/i2c_slave_regif_if.sv
// Single-cycle local register bus between the I2C target (master side) and a register file.
// Latency: read data due the clk after reg_rd; backpressure: none, strobes are fire-and-forget.
interface i2c_slave_regif_if;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic        reg_wr;
    logic        reg_rd;
    logic [7:0]  reg_rdata;

    modport master (output reg_addr, reg_wdata, reg_wr, reg_rd, input reg_rdata);
    modport slave  (input reg_addr, reg_wdata, reg_wr, reg_rd, output reg_rdata);
endinterface

// File: rtl/i2c_in_filter.sv
// Two-flop synchronizer plus glitch filter for one open-drain pad input; idles high.
// Latency: 2 + FILT_LEN clks; backpressure: none.
module i2c_in_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    localparam int CW = $clog2(FILT_LEN + 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    // Output follows only after FILT_LEN consecutive samples disagree with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            dout <= 1'b1;
            cnt  <= '0;
        end else begin
            s1 <= din;
            s2 <= s1;
            if (s2 == dout) begin
                cnt <= '0;
            end else if (cnt == CW'(FILT_LEN - 1)) begin
                dout <= s2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/i2c_slave_regif.sv
// I2C target bridging register-write/read transactions onto a single-cycle local register bus.
// Latency: SDA driven 1 clk after filtered SCL fall; backpressure: none (SCL stretching unsupported).
module i2c_slave_regif
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h2b,
    parameter logic       BIT_CTRL   = 1'b1,
    parameter int         FILT_LEN   = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_oe,
    output logic busy,
    i2c_slave_regif_if.master regbus
);
    logic        scl_f, sda_f, scl_d, sda_d;
    logic        scl_rise, scl_fall, start_det, stop_det;
    logic [3:0]  state;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic [7:0]  byte_in;
    logic        rw;
    logic        ra_hi_done;
    logic [1:0]  rd_ph;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic        reg_wr, reg_rd;

    i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (.clk(clk), .rst(rst), .din(scl_in), .dout(scl_f));
    i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (.clk(clk), .rst(rst), .din(sda_in), .dout(sda_f));

    assign scl_rise  = scl_f & ~scl_d;
    assign scl_fall  = ~scl_f & scl_d;
    assign start_det = scl_f & scl_d & sda_d & ~sda_f;
    assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;
    assign byte_in   = {shift[6:0], sda_f};

    assign regbus.reg_addr  = reg_addr;
    assign regbus.reg_wdata = reg_wdata;
    assign regbus.reg_wr    = reg_wr;
    assign regbus.reg_rd    = reg_rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_d      <= 1'b1;
            sda_d      <= 1'b1;
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            rw         <= RW_WRITE;
            ra_hi_done <= 1'b0;
            rd_ph      <= '0;
            sda_oe     <= 1'b0;
            busy       <= 1'b0;
            reg_addr   <= '0;
            reg_wdata  <= '0;
            reg_wr     <= 1'b0;
            reg_rd     <= 1'b0;
        end else begin
            scl_d  <= scl_f;
            sda_d  <= sda_f;
            reg_wr <= 1'b0;
            reg_rd <= 1'b0;
            if (reg_wr)
                reg_addr <= addr_inc(reg_addr, BIT_CTRL);

            if (stop_det) begin
                state  <= ST_IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (start_det) begin
                state   <= ST_DEV_ADDR;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: ;
                    ST_DEV_ADDR, ST_RA_H, ST_RA_L, ST_WR_DATA: if (scl_rise) begin
                        shift   <= byte_in;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            case (state)
                                ST_DEV_ADDR: begin
                                    if (byte_in[7:1] == SLAVE_ADDR) begin
                                        state <= ST_DEV_ACK;
                                        busy  <= 1'b1;
                                        rw    <= byte_in[0];
                                    end else begin
                                        state <= ST_WAIT_STOP;
                                    end
                                end
                                ST_RA_H: begin
                                    reg_addr[15:8] <= byte_in;
                                    ra_hi_done     <= 1'b1;
                                    state          <= ST_RA_ACK;
                                end
                                ST_RA_L: begin
                                    reg_addr[7:0] <= byte_in;
                                    ra_hi_done    <= 1'b0;
                                    state         <= ST_RA_ACK;
                                end
                                default: begin
                                    reg_wdata <= byte_in;
                                    reg_wr    <= 1'b1;
                                    state     <= ST_WR_ACK;
                                end
                            endcase
                        end
                    end
                    // First fall after the byte starts the ACK pulse, the next one ends it.
                    ST_DEV_ACK, ST_RA_ACK, ST_WR_ACK: if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                            rd_ph   <= '0;
                            if (state == ST_DEV_ACK)
                                state <= (rw == RW_READ) ? ST_RD_LOAD : (BIT_CTRL ? ST_RA_H : ST_RA_L);
                            else if (state == ST_RA_ACK)
                                state <= ra_hi_done ? ST_RA_L : ST_WR_DATA;
                            else
                                state <= ST_WR_DATA;
                        end
                    end
                    ST_RD_LOAD: begin
                        rd_ph <= rd_ph + 2'd1;
                        case (rd_ph)
                            2'd0: reg_rd <= 1'b1;
                            2'd1: ;
                            2'd2: shift <= regbus.reg_rdata;
                            default: begin
                                // Hold until SCL is low so SDA never moves while SCL is high.
                                rd_ph <= rd_ph;
                                if (!scl_f) begin
                                    sda_oe  <= ~shift[7];
                                    shift   <= {shift[6:0], 1'b0};
                                    bit_cnt <= '0;
                                    state   <= ST_RD_DATA;
                                end
                            end
                        endcase
                    end
                    ST_RD_DATA: if (scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            sda_oe <= 1'b0;
                            state  <= ST_RD_MACK;
                        end else begin
                            sda_oe  <= ~shift[7];
                            shift   <= {shift[6:0], 1'b0};
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    ST_RD_MACK: if (scl_rise) begin
                        if (sda_f == ACK) begin
                            reg_addr <= addr_inc(reg_addr, BIT_CTRL);
                            rd_ph    <= '0;
                            state    <= ST_RD_LOAD;
                        end else begin
                            busy  <= 1'b0;
                            state <= ST_WAIT_STOP;
                        end
                    end
                    ST_WAIT_STOP: sda_oe <= 1'b0;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_slave_regif.sv
// Directed bench for i2c_slave_regif: bit-banged I2C master plus a register model returning addr^0x5A.
module tb_i2c_slave_regif;
    import i2c_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic scl_m, sda_m;
    logic sda_oe, busy;
    logic sda_line;

    always #5 clk = ~clk;

    i2c_slave_regif_if rb();

    assign sda_line = sda_m & ~sda_oe;

    i2c_slave_regif dut (
        .clk(clk), .rst(rst), .scl_in(scl_m), .sda_in(sda_line),
        .sda_oe(sda_oe), .busy(busy), .regbus(rb)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] wr_addr [16];
    logic [7:0]  wr_dat  [16];
    logic [15:0] rd_addr [16];
    int          wr_n = 0;
    int          rd_n = 0;
    logic        mon_en = 1'b0;
    logic        saw_nonidle = 1'b0;

    always @(posedge clk) begin
        if (rb.reg_wr && wr_n < 16) begin
            wr_addr[wr_n] <= rb.reg_addr;
            wr_dat[wr_n]  <= rb.reg_wdata;
            wr_n          <= wr_n + 1;
        end
        if (rb.reg_rd && rd_n < 16) begin
            rd_addr[rd_n] <= rb.reg_addr;
            rd_n          <= rd_n + 1;
        end
        if (rb.reg_rd)
            rb.reg_rdata <= rb.reg_addr[7:0] ^ 8'h5A;
        if (mon_en && dut.state != ST_IDLE)
            saw_nonidle <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic q();
        repeat (10) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; q();
        scl_m = 1'b1; q();
        sda_m = 1'b0; q();
        scl_m = 1'b0; q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; q();
        scl_m = 1'b1; q();
        sda_m = 1'b1; q();
    endtask

    task automatic wbit(input logic b);
        sda_m = b; q();
        scl_m = 1'b1; q(); q();
        scl_m = 1'b0; q();
    endtask

    task automatic rbit(output logic b);
        sda_m = 1'b1; q();
        scl_m = 1'b1; q();
        b = sda_line; q();
        scl_m = 1'b0; q();
    endtask

    task automatic wbyte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) wbit(d[i]);
        rbit(ack);
    endtask

    task automatic rbyte(output logic [7:0] d, input logic mack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rbit(b);
            d[i] = b;
        end
        wbit(mack);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack;
        logic [7:0] d;
        logic       seen;

        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_sda_oe", 32'(sda_oe), 0);
        check("rst_addr",   32'(rb.reg_addr), 0);
        check("rst_wdata",  32'(rb.reg_wdata), 0);
        check("rst_wr",     32'(rb.reg_wr), 0);
        check("rst_rd",     32'(rb.reg_rd), 0);
        check("rst_busy",   32'(busy), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single write 0xA5 to 0x1234
        i2c_start();
        wbyte(8'h56, ack); check("w_dev_ack", 32'(ack), 0);
        wbyte(8'h12, ack); check("w_rah_ack", 32'(ack), 0);
        wbyte(8'h34, ack); check("w_ral_ack", 32'(ack), 0);
        wbyte(8'hA5, ack); check("w_dat_ack", 32'(ack), 0);
        check("w_busy_on", 32'(busy), 1);
        i2c_stop(); q();
        check("w_busy_off", 32'(busy), 0);
        check("w_count", 32'(wr_n), 1);
        check("w_addr0", 32'(wr_addr[0]), 32'h1234);
        check("w_data0", 32'(wr_dat[0]), 32'hA5);
        check("w_ptr_end", 32'(rb.reg_addr), 32'h1235);

        // Burst write across the 0xFFFF wrap
        i2c_start();
        wbyte(8'h56, ack); check("b_dev_ack", 32'(ack), 0);
        wbyte(8'hFF, ack); check("b_rah_ack", 32'(ack), 0);
        wbyte(8'hFF, ack); check("b_ral_ack", 32'(ack), 0);
        wbyte(8'h01, ack); check("b_d1_ack", 32'(ack), 0);
        wbyte(8'h02, ack); check("b_d2_ack", 32'(ack), 0);
        wbyte(8'h03, ack); check("b_d3_ack", 32'(ack), 0);
        i2c_stop(); q();
        check("b_count", 32'(wr_n), 4);
        check("b_addr1", 32'(wr_addr[1]), 32'hFFFF);
        check("b_data1", 32'(wr_dat[1]), 32'h01);
        check("b_addr2", 32'(wr_addr[2]), 32'h0000);
        check("b_data2", 32'(wr_dat[2]), 32'h02);
        check("b_addr3", 32'(wr_addr[3]), 32'h0001);
        check("b_data3", 32'(wr_dat[3]), 32'h03);
        check("b_ptr_end", 32'(rb.reg_addr), 32'h0002);

        // Pointer write, repeated START, 3-byte read ending in NACK
        i2c_start();
        wbyte(8'h56, ack); check("r_dev_ack", 32'(ack), 0);
        wbyte(8'h00, ack); check("r_rah_ack", 32'(ack), 0);
        wbyte(8'h10, ack); check("r_ral_ack", 32'(ack), 0);
        i2c_start();
        wbyte(8'h57, ack); check("r_devr_ack", 32'(ack), 0);
        rbyte(d, ACK);  check("r_byte0", 32'(d), 32'h4A);
        rbyte(d, ACK);  check("r_byte1", 32'(d), 32'h4B);
        rbyte(d, NACK); check("r_byte2", 32'(d), 32'h48);
        q();
        check("r_sda_rel", 32'(sda_oe), 0);
        check("r_busy_nack", 32'(busy), 0);
        check("r_rd_count", 32'(rd_n), 3);
        check("r_rd_addr0", 32'(rd_addr[0]), 32'h10);
        check("r_rd_addr1", 32'(rd_addr[1]), 32'h11);
        check("r_rd_addr2", 32'(rd_addr[2]), 32'h12);
        check("r_no_wr", 32'(wr_n), 4);
        i2c_stop(); q();
        check("r_ptr_end", 32'(rb.reg_addr), 32'h0012);

        // Foreign address 0x30 is ignored
        i2c_start();
        wbyte(8'h60, ack); check("n_dev_nack", 32'(ack), 1);
        check("n_busy", 32'(busy), 0);
        wbyte(8'h00, ack); check("n_byte_nack", 32'(ack), 1);
        i2c_stop(); q();
        check("n_no_wr", 32'(wr_n), 4);
        check("n_no_rd", 32'(rd_n), 3);

        // 1-clk glitches on an idle bus
        mon_en = 1'b1;
        scl_m = 1'b0; @(negedge clk); scl_m = 1'b1;
        repeat (20) @(negedge clk);
        sda_m = 1'b0; @(negedge clk); sda_m = 1'b1;
        repeat (20) @(negedge clk);
        mon_en = 1'b0;
        check("g_no_start", 32'(saw_nonidle), 0);
        check("g_busy", 32'(busy), 0);

        // STOP in the middle of the pointer high byte
        i2c_start();
        wbyte(8'h56, ack); check("s_dev_ack", 32'(ack), 0);
        wbit(1'b1); wbit(1'b0); wbit(1'b1);
        check("s_mid_state", 32'(dut.state), 32'(ST_RA_H));
        check("s_mid_busy", 32'(busy), 1);
        i2c_stop(); q();
        check("s_idle", 32'(dut.state), 32'(ST_IDLE));
        check("s_sda_oe", 32'(sda_oe), 0);
        check("s_busy", 32'(busy), 0);

        // Reset while the target is pulling SDA during a read
        i2c_start();
        wbyte(8'h56, ack);
        wbyte(8'h00, ack);
        wbyte(8'h10, ack);
        i2c_start();
        wbyte(8'h57, ack); check("x_devr_ack", 32'(ack), 0);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = sda_oe;
        end
        check("x_oe_seen", 32'(seen), 1);
        rst = 1'b1; #1;
        check("x_oe_async", 32'(sda_oe), 0);
        check("x_busy_async", 32'(busy), 0);
        scl_m = 1'b1; sda_m = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        i2c_start();
        wbyte(8'h56, ack); check("x_dev_ack", 32'(ack), 0);
        wbyte(8'h00, ack); check("x_rah_ack", 32'(ack), 0);
        wbyte(8'h20, ack); check("x_ral_ack", 32'(ack), 0);
        wbyte(8'h77, ack); check("x_dat_ack", 32'(ack), 0);
        i2c_stop(); q();
        check("x_count", 32'(wr_n), 5);
        check("x_addr", 32'(wr_addr[4]), 32'h0020);
        check("x_data", 32'(wr_dat[4]), 32'h77);
        check("x_ptr_end", 32'(rb.reg_addr), 32'h0021);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
